// File: rtl/dot_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dot_matrix_pkg
// Purpose : Shared definitions for the dot-matrix scanner: display mode
//           encoding, swap-control state encoding and the row-select helper.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package dot_matrix_pkg;

    // Display mode encoding. Code 3 is reserved and behaves like blank.
    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_TEST   = 2'd1;
    localparam logic [1:0] MODE_BLANK  = 2'd2;

    // Front/back swap request tracking.
    typedef enum logic [0:0] {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    // Level of row-select line 'pos' when row 'idx' is being scanned.
    // 'enable' low leaves every row inactive (blank display).
    function automatic logic row_level(
        input int unsigned pos,
        input int unsigned idx,
        input logic        enable,
        input logic        active_low
    );
        logic selected;
        selected = enable && (pos == idx);
        return active_low ^ selected;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dot_matrix_scan_if.sv
`default_nettype none
// ============================================================================
// Module  : dot_matrix_scan_if
// Purpose : Producer-side bus of the scanner: row write port plus the
//           frame-synchronous swap handshake.
// Signals : wr_en/wr_row/wr_red/wr_grn - write one row of the back buffer
//           swap_req                    - request a front/back exchange
//           swap_ack                    - pulse when the exchange happens
//           swap_pending                - request accepted, not yet done
// Modports: master (producer), slave (scanner)
// Revision: 1.0  initial release
// ============================================================================
interface dot_matrix_scan_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int RW = $clog2(ROWS);

    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_red;
    logic [COLS-1:0] wr_grn;
    logic            swap_req;
    logic            swap_ack;
    logic            swap_pending;

    modport master (
        output wr_en, wr_row, wr_red, wr_grn, swap_req,
        input  swap_ack, swap_pending
    );

    modport slave (
        input  wr_en, wr_row, wr_red, wr_grn, swap_req,
        output swap_ack, swap_pending
    );

endinterface
`default_nettype wire

// File: rtl/dms_frame_store.sv
`default_nettype none
// ============================================================================
// Module  : dms_frame_store
// Purpose : Double-buffered frame store. Two banks of ROWS entries, each
//           entry {red[COLS-1:0], grn[COLS-1:0]}. Writes always go to the
//           bank not selected as front; reads return the front bank row.
// Ports   : clk_1kHz, rst_n           - clock, async active-low reset
//           wr_en/wr_row/wr_red/wr_grn - back-buffer row write
//           front_sel                 - bank currently displayed
//           rd_row                    - row to read from the front bank
//           rd_red/rd_grn             - combinational front-row data
// Revision: 1.0  initial release
// ============================================================================
module dms_frame_store #(
    parameter int ROWS = 8,
    parameter int COLS = 8
) (
    input  wire logic                     clk_1kHz,
    input  wire logic                     rst_n,
    input  wire logic                     wr_en,
    input  wire logic [$clog2(ROWS)-1:0]  wr_row,
    input  wire logic [COLS-1:0]          wr_red,
    input  wire logic [COLS-1:0]          wr_grn,
    input  wire logic                     front_sel,
    input  wire logic [$clog2(ROWS)-1:0]  rd_row,
    output logic      [COLS-1:0]          rd_red,
    output logic      [COLS-1:0]          rd_grn
);
    localparam int            RW     = $clog2(ROWS);
    localparam logic [RW:0]   c_rows = (RW+1)'(ROWS);

    // Out-of-range row indices (possible when ROWS is not a power of two)
    // are dropped instead of aliasing onto a real row.
    logic w_wr_valid;
    assign w_wr_valid = ({1'b0, wr_row} < c_rows);

    logic [2*COLS-1:0] w_rd_bank0;
    logic [2*COLS-1:0] w_rd_bank1;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic c_bank_id = (b == 1);

        logic [2*COLS-1:0] r_data [ROWS];
        logic              w_we;

        assign w_we = wr_en && w_wr_valid && (front_sel != c_bank_id);

        always_ff @(posedge clk_1kHz or negedge rst_n) begin
            if (!rst_n) begin
                for (int r = 0; r < ROWS; r++) begin
                    r_data[r] <= '0;
                end
            end else if (w_we) begin
                r_data[wr_row] <= {wr_red, wr_grn};
            end
        end
    end

    assign w_rd_bank0 = g_bank[0].r_data[rd_row];
    assign w_rd_bank1 = g_bank[1].r_data[rd_row];

    always_comb begin
        rd_red = front_sel ? w_rd_bank1[2*COLS-1:COLS] : w_rd_bank0[2*COLS-1:COLS];
        rd_grn = front_sel ? w_rd_bank1[COLS-1:0]      : w_rd_bank0[COLS-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/dot_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module  : dot_matrix_scan
// Purpose : ROWS x COLS red/green dot-matrix scanner with a double-buffered
//           frame store, frame-synchronous buffer swap, per-row PWM
//           brightness and test/blank modes.
// Ports   : clk_1kHz     - scan clock (rising edge)
//           rst_n        - asynchronous active-low reset
//           bus          - write port + swap handshake (slave modport)
//           mode         - 0 normal, 1 test, 2/3 blank
//           bright       - columns lit for bright+1 clocks of each row slot
//           row          - row select, one row active at a time
//           col_r/col_g  - red/green column drive
//           frame_start  - pulse with the first output clock of row 0
// Revision: 1.0  initial release
// ============================================================================
module dot_matrix_scan
    import dot_matrix_pkg::*;
#(
    parameter int ROWS           = 8,   // >= 2, <= 2**31
    parameter int COLS           = 8,
    parameter int DIM_BITS       = 2,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  wire logic                clk_1kHz,
    input  wire logic                rst_n,
    dot_matrix_scan_if.slave         bus,
    input  wire logic [1:0]          mode,
    input  wire logic [DIM_BITS-1:0] bright,
    output logic      [ROWS-1:0]     row,
    output logic      [COLS-1:0]     col_r,
    output logic      [COLS-1:0]     col_g,
    output logic                     frame_start
);
    localparam int                  RW           = $clog2(ROWS);
    localparam logic [DIM_BITS-1:0] c_sub_max    = '1;
    localparam logic [RW-1:0]       c_row_last   = RW'(ROWS - 1);
    localparam logic                c_active_low = (ROW_ACTIVE_LOW != 0);
    localparam logic [ROWS-1:0]     c_row_idle   = {ROWS{c_active_low}};

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [DIM_BITS-1:0] r_sub;
    logic [RW-1:0]       r_row_idx;
    logic                w_sub_wrap;
    logic                w_boundary;

    assign w_sub_wrap = (r_sub == c_sub_max);
    // The clock on which row_idx wraps back to 0 is the frame boundary.
    assign w_boundary = w_sub_wrap && (r_row_idx == c_row_last);

    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            r_sub     <= '0;
            r_row_idx <= '0;
        end else begin
            r_sub <= r_sub + 1'b1;
            if (w_sub_wrap) begin
                r_row_idx <= (r_row_idx == c_row_last) ? '0 : r_row_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Swap control
    // ------------------------------------------------------------------
    swap_state_t r_swap_state;
    swap_state_t w_swap_next;
    logic        w_do_swap;
    logic        r_front;
    logic        r_swap_ack;

    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            r_swap_state <= SWAP_IDLE;
        end else begin
            r_swap_state <= w_swap_next;
        end
    end

    // A request arriving on a boundary clock with nothing pending only
    // arms the swap; it executes at the following boundary. Requests seen
    // while already pending merge into the outstanding one.
    always_comb begin
        w_swap_next = r_swap_state;
        w_do_swap   = 1'b0;
        case (r_swap_state)
            SWAP_IDLE: begin
                if (bus.swap_req) begin
                    w_swap_next = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (w_boundary) begin
                    w_do_swap   = 1'b1;
                    w_swap_next = SWAP_IDLE;
                end
            end
            default: begin
                w_swap_next = SWAP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            r_front    <= 1'b0;
            r_swap_ack <= 1'b0;
        end else begin
            r_swap_ack <= w_do_swap;
            if (w_do_swap) begin
                r_front <= ~r_front;
            end
        end
    end

    assign bus.swap_ack     = r_swap_ack;
    assign bus.swap_pending = (r_swap_state == SWAP_PENDING);

    // ------------------------------------------------------------------
    // Frame store. The write bank is chosen from the pre-swap front
    // select, so a write on the swap clock lands in the new front.
    // ------------------------------------------------------------------
    logic [COLS-1:0] w_front_red;
    logic [COLS-1:0] w_front_grn;

    dms_frame_store #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_store (
        .clk_1kHz  (clk_1kHz),
        .rst_n     (rst_n),
        .wr_en     (bus.wr_en),
        .wr_row    (bus.wr_row),
        .wr_red    (bus.wr_red),
        .wr_grn    (bus.wr_grn),
        .front_sel (r_front),
        .rd_row    (r_row_idx),
        .rd_red    (w_front_red),
        .rd_grn    (w_front_grn)
    );

    // ------------------------------------------------------------------
    // Output generation (registered, one clock behind the counters)
    // ------------------------------------------------------------------
    logic            w_lit;
    logic            w_row_on;
    logic [ROWS-1:0] w_row_next;
    logic [COLS-1:0] w_col_r_next;
    logic [COLS-1:0] w_col_g_next;

    // PWM gate: the row stays selected for the whole slot, only the
    // columns are switched off after bright+1 clocks.
    assign w_lit    = (r_sub <= bright);
    assign w_row_on = (mode == MODE_NORMAL) || (mode == MODE_TEST);

    for (genvar g = 0; g < ROWS; g++) begin : g_row_sel
        assign w_row_next[g] = row_level(g, 32'(r_row_idx), w_row_on, c_active_low);
    end

    always_comb begin
        w_col_r_next = '0;
        w_col_g_next = '0;
        case (mode)
            MODE_NORMAL: begin
                w_col_r_next = w_front_red & {COLS{w_lit}};
                w_col_g_next = w_front_grn & {COLS{w_lit}};
            end
            MODE_TEST: begin
                w_col_r_next = {COLS{w_lit}};
                w_col_g_next = {COLS{w_lit}};
            end
            default: begin
                w_col_r_next = '0;
                w_col_g_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_1kHz or negedge rst_n) begin
        if (!rst_n) begin
            row         <= c_row_idle;
            col_r       <= '0;
            col_g       <= '0;
            frame_start <= 1'b0;
        end else begin
            row         <= w_row_next;
            col_r       <= w_col_r_next;
            col_g       <= w_col_g_next;
            frame_start <= (r_row_idx == '0) && (r_sub == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dot_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_dot_matrix_scan
// Purpose : Self-checking bench for dot_matrix_scan (8x8, DIM_BITS = 2,
//           active-low rows). A frame-position model predicts every output
//           each clock; directed steps add literal expectations.
// Revision: 1.0  initial release
// ============================================================================
module tb_dot_matrix_scan;
    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int DIM_BITS = 2;
    localparam int SLOT     = 4;            // clocks per row
    localparam int FRAME    = ROWS * SLOT;  // clocks per frame

    logic       clk_1kHz = 1'b0;
    logic       rst_n    = 1'b0;
    logic [1:0] mode     = 2'd0;
    logic [1:0] bright   = 2'd3;
    logic [7:0] row;
    logic [7:0] col_r;
    logic [7:0] col_g;
    logic       frame_start;

    dot_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    dot_matrix_scan #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .DIM_BITS       (DIM_BITS),
        .ROW_ACTIVE_LOW (1)
    ) dut (
        .clk_1kHz    (clk_1kHz),
        .rst_n       (rst_n),
        .bus         (bus),
        .mode        (mode),
        .bright      (bright),
        .row         (row),
        .col_r       (col_r),
        .col_g       (col_g),
        .frame_start (frame_start)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Model: frame position since reset release, two buffers, front index.
    // ------------------------------------------------------------------
    logic [7:0] m_red [2][ROWS];
    logic [7:0] m_grn [2][ROWS];
    int         m_front;
    bit         m_pend;
    int         m_pos;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++) begin
                m_red[b][r] = 8'h00;
                m_grn[b][r] = 8'h00;
            end
        m_front = 0;
        m_pend  = 1'b0;
        m_pos   = 0;
    endtask

    initial begin
        logic       s_rst, s_wr_en, s_req;
        logic [1:0] s_mode, s_bright;
        logic [2:0] s_wr_row;
        logic [7:0] s_wr_red, s_wr_grn;
        logic [7:0] e_row, e_cr, e_cg;
        logic       e_fs, e_ack, e_pend;
        int         r, s;
        bit         lit, boundary;
        model_reset();
        forever begin
            @(posedge clk_1kHz);
            s_rst    = rst_n;
            s_mode   = mode;
            s_bright = bright;
            s_wr_en  = bus.wr_en;
            s_wr_row = bus.wr_row;
            s_wr_red = bus.wr_red;
            s_wr_grn = bus.wr_grn;
            s_req    = bus.swap_req;
            if (!s_rst) begin
                model_reset();
                e_row = 8'hFF; e_cr = 8'h00; e_cg = 8'h00;
                e_fs = 1'b0; e_ack = 1'b0; e_pend = 1'b0;
            end else begin
                r        = (m_pos / SLOT) % ROWS;
                s        = m_pos % SLOT;
                lit      = (s <= int'(s_bright));
                boundary = ((m_pos % FRAME) == FRAME - 1);
                e_row = (s_mode >= 2) ? 8'hFF : ~(8'h01 << r);
                if (s_mode == 2'd0) begin
                    e_cr = lit ? m_red[m_front][r] : 8'h00;
                    e_cg = lit ? m_grn[m_front][r] : 8'h00;
                end else if (s_mode == 2'd1) begin
                    e_cr = lit ? 8'hFF : 8'h00;
                    e_cg = e_cr;
                end else begin
                    e_cr = 8'h00;
                    e_cg = 8'h00;
                end
                e_fs  = ((m_pos % FRAME) == 0);
                e_ack = boundary && m_pend;
                if (s_wr_en && (int'(s_wr_row) < ROWS)) begin
                    m_red[1 - m_front][s_wr_row] = s_wr_red;
                    m_grn[1 - m_front][s_wr_row] = s_wr_grn;
                end
                if (boundary && m_pend) begin
                    m_front = 1 - m_front;
                    m_pend  = 1'b0;
                end else if (s_req) begin
                    m_pend = 1'b1;
                end
                e_pend = m_pend;
                m_pos++;
            end
            #1;
            chk("row", row, e_row);
            chk("col_r", col_r, e_cr);
            chk("col_g", col_g, e_cg);
            chk("frame_start", frame_start, e_fs);
            chk("swap_ack", bus.swap_ack, e_ack);
            chk("swap_pending", bus.swap_pending, e_pend);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk_1kHz);
    endtask

    // Waits for the first clock of a new slot showing 'target'.
    task automatic wait_row_start(input logic [7:0] target, input string name);
        int n = 0;
        while (row === target && n < 100) begin tick(1); n++; end
        while (row !== target && n < 100) begin tick(1); n++; end
        if (row !== target) timeout(name);
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (bus.swap_ack !== 1'b1 && n < 2 * FRAME) begin tick(1); n++; end
        if (bus.swap_ack !== 1'b1) timeout(name);
    endtask

    task automatic write_row(input logic [2:0] r, input logic [7:0] red, input logic [7:0] grn);
        bus.wr_en = 1'b1; bus.wr_row = r; bus.wr_red = red; bus.wr_grn = grn;
        tick(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        bus.swap_req = 1'b1;
        tick(1);
        bus.swap_req = 1'b0;
    endtask

    initial begin
        int n;
        bus.wr_en = 1'b0; bus.wr_row = 3'd0; bus.wr_red = 8'h00; bus.wr_grn = 8'h00;
        bus.swap_req = 1'b0;

        // Reset state
        tick(3);
        chk("rst_row", row, 8'hFF);
        chk("rst_col_r", col_r, 8'h00);
        chk("rst_fs", frame_start, 1'b0);
        rst_n = 1'b1;

        // First output after release: row 0, sub 0, frame_start
        tick(1);
        chk("first_row", row, 8'hFE);
        chk("first_fs", frame_start, 1'b1);
        tick(4);
        chk("second_row", row, 8'hFD);
        chk("second_fs", frame_start, 1'b0);
        tick(27);
        chk("last_row", row, 8'h7F);
        tick(1);
        chk("wrap_fs", frame_start, 1'b1);
        tick(FRAME);

        // Load row 3 and swap at the next boundary
        write_row(3'd3, 8'hA5, 8'h0F);
        pulse_swap();
        chk("pending_set", bus.swap_pending, 1'b1);
        wait_ack("ack_wait");
        wait_row_start(8'hF7, "row3_wait");
        chk("swap_col_r", col_r, 8'hA5);
        chk("swap_col_g", col_g, 8'h0F);

        // Minimum brightness: only sub 0 lit, row held
        bright = 2'd0;
        wait_row_start(8'hF7, "dim_wait");
        chk("dim_col_r_sub0", col_r, 8'hA5);
        tick(1);
        chk("dim_col_r_sub1", col_r, 8'h00);
        chk("dim_row_sub1", row, 8'hF7);
        bright = 2'd3;

        // Back-buffer write without swap leaves display unchanged
        write_row(3'd3, 8'h3C, 8'hC3);
        tick(3 * FRAME);
        chk("no_swap_pending", bus.swap_pending, 1'b0);
        wait_row_start(8'hF7, "noswap_wait");
        chk("noswap_col_r", col_r, 8'hA5);
        chk("noswap_col_g", col_g, 8'h0F);

        // Test and blank modes
        mode = 2'd1;
        tick(1);
        chk("test_col_r", col_r, 8'hFF);
        chk("test_col_g", col_g, 8'hFF);
        tick(FRAME);
        mode = 2'd2;
        tick(1);
        chk("blank_row", row, 8'hFF);
        chk("blank_col_r", col_r, 8'h00);
        tick(FRAME);
        mode = 2'd3;
        tick(5);
        chk("resv_row", row, 8'hFF);
        mode = 2'd0;
        tick(FRAME);

        // Swap requested mid-frame, then reset before the boundary
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME) begin tick(1); n++; end
        if (frame_start !== 1'b1) timeout("fs_wait");
        tick(5);
        pulse_swap();
        chk("pending_mid", bus.swap_pending, 1'b1);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("abort_row", row, 8'hFF);
        chk("abort_col_g", col_g, 8'h00);
        chk("abort_pending", bus.swap_pending, 1'b0);
        tick(2);
        rst_n = 1'b1;
        wait_row_start(8'hF7, "post_rst_wait");
        chk("post_rst_col_r", col_r, 8'h00);
        tick(2 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
